// File: rtl/chess_pkg.sv
// chess_pkg: piece codes, colour bits, RGB palette and 8x8 sprite art for the board renderer.
package chess_pkg;
  typedef enum logic [2:0] {
    P_NONE, P_PAWN, P_KNIGHT, P_BISHOP, P_ROOK, P_QUEEN, P_KING, P_OUT
  } piece_t;
  localparam logic COL_WHITE = 1'b0;
  localparam logic COL_BLACK = 1'b1;
  localparam logic [7:0] RGB_OUTSIDE  = 8'b000_000_00;
  localparam logic [7:0] RGB_DARK     = 8'b101_000_00;
  localparam logic [7:0] RGB_LIGHT    = 8'b111_110_10;
  localparam logic [7:0] RGB_BLACK_PC = 8'b010_010_01;
  localparam logic [7:0] RGB_WHITE_PC = 8'b110_110_10;
  localparam logic [7:0] RGB_CURSOR   = 8'b000_000_11;
  localparam logic [7:0] RGB_SELECTED = 8'b111_000_00;
  localparam logic [7:0] RGB_LASTMOVE = 8'b110_101_00;
  // Top art row is the most significant byte, leftmost art pixel is the byte MSB.
  localparam logic [63:0] SPR_PAWN   = 64'h00183C3C183C7E00;
  localparam logic [63:0] SPR_KNIGHT = 64'h00183C6C1C387C00;
  localparam logic [63:0] SPR_BISHOP = 64'h0018342C18183C00;
  localparam logic [63:0] SPR_ROOK   = 64'h005A7E3C3C3C7E00;
  localparam logic [63:0] SPR_QUEEN  = 64'h00995A3C3C3C7E00;
  localparam logic [63:0] SPR_KING   = 64'h00183C183C3C7E00;

  function automatic logic sprite_bit(input logic [2:0] piece, input logic [2:0] ar,
                                      input logic [2:0] ac);
    logic [63:0] s;
    s = (piece == P_PAWN)   ? SPR_PAWN   :
        (piece == P_KNIGHT) ? SPR_KNIGHT :
        (piece == P_BISHOP) ? SPR_BISHOP :
        (piece == P_ROOK)   ? SPR_ROOK   :
        (piece == P_QUEEN)  ? SPR_QUEEN  :
        (piece == P_KING)   ? SPR_KING   : 64'h0;
    return s[~{ar, ac}];
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised H/V pixel counters with raw sync, active and end-of-frame flags.
module vga_timing_gen
  import chess_pkg::*;
#(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   XW          = 10,
  parameter int   YW          = 10
) (
  input  logic          CLK,
  input  logic          RESET,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          frame_last
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic x_end, y_end;
  assign x_end = x == XW'(HT - 1);
  assign y_end = y == YW'(VT - 1);
  assign frame_last = x_end && y_end;
  assign active = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
  assign hsync = ((x >= XW'(H_ACTIVE + H_FP)) && (x < XW'(H_ACTIVE + H_FP + H_SYNC))) ?
                 SYNC_ACTIVE : !SYNC_ACTIVE;
  assign vsync = ((y >= YW'(V_ACTIVE + V_FP)) && (y < YW'(V_ACTIVE + V_FP + V_SYNC))) ?
                 SYNC_ACTIVE : !SYNC_ACTIVE;

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_end ? '0 : x + 1'b1;
      if (x_end) y <= y_end ? '0 : y + 1'b1;
    end
endmodule

// File: rtl/board_renderer_pipe.sv
// board_renderer_pipe: 3-stage pipelined 8x8 chess board VGA renderer with flip, last-move
// highlight and blinking cursor, drawing each frame from a shadow copy of the game state.
module board_renderer_pipe
  import chess_pkg::*;
#(
  parameter int   H_ACTIVE     = 640,
  parameter int   H_FP         = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BP         = 48,
  parameter int   V_ACTIVE     = 480,
  parameter int   V_FP         = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BP         = 33,
  parameter logic SYNC_ACTIVE  = 1'b0,
  parameter int   BOARD_X0     = 120,
  parameter int   BOARD_Y0     = 40,
  parameter int   SQ_SIZE      = 50,
  parameter int   BORDER       = 5,
  parameter int   ART_SCALE    = 5,
  parameter int   BLINK_FRAMES = 30
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [255:0] BOARD,
  input  logic [5:0]   CURSOR_ADDR,
  input  logic [5:0]   SELECT_ADDR,
  input  logic         SELECT_EN,
  input  logic [5:0]   LAST_FROM,
  input  logic [5:0]   LAST_TO,
  input  logic         LAST_EN,
  input  logic         FLIP,
  output logic         HSYNC,
  output logic         VSYNC,
  output logic [2:0]   R,
  output logic [2:0]   G,
  output logic [1:0]   B,
  output logic         FRAME_START
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int OW = $clog2(SQ_SIZE);
  localparam int AW = $clog2(ART_SCALE + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic hs_raw, vs_raw, act_raw, frame_last;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_ACTIVE(SYNC_ACTIVE), .XW(XW), .YW(YW)
  ) u_timing (
    .CLK(CLK), .RESET(RESET), .x(x), .y(y), .hsync(hs_raw), .vsync(vs_raw),
    .active(act_raw), .frame_last(frame_last)
  );

  logic [255:0]  sh_board;
  logic [5:0]    sh_cur, sh_sel, sh_from, sh_to;
  logic          sh_sel_en, sh_last_en, sh_flip, blink, blink_wrap;
  logic [BW-1:0] blink_cnt;
  assign blink_wrap = blink_cnt == BW'(BLINK_FRAMES - 1);

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      sh_board   <= '0;
      sh_cur     <= '0;
      sh_sel     <= '0;
      sh_from    <= '0;
      sh_to      <= '0;
      sh_sel_en  <= 1'b0;
      sh_last_en <= 1'b0;
      sh_flip    <= 1'b0;
      blink_cnt  <= '0;
      blink      <= 1'b0;
    end else if (frame_last) begin
      sh_board   <= BOARD;
      sh_cur     <= CURSOR_ADDR;
      sh_sel     <= SELECT_ADDR;
      sh_from    <= LAST_FROM;
      sh_to      <= LAST_TO;
      sh_sel_en  <= SELECT_EN;
      sh_last_en <= LAST_EN;
      sh_flip    <= FLIP;
      blink_cnt  <= blink_wrap ? '0 : blink_cnt + 1'b1;
      blink      <= blink ^ blink_wrap;
    end

  // S1: square/offset/art sub-counters step along with the pixel counters instead of dividing.
  logic [OW-1:0] ox, oy, ox_n, oy_n;
  logic [2:0]    cx, cy, cx_n, cy_n, ax, ay, ax_n, ay_n;
  logic [AW-1:0] sx, sy, sx_n, sy_n;
  logic          x0, xw, xa0, y0, yw, ya0;
  logic          s1_inb, s1_act, s1_hs, s1_vs, s1_fs;

  always_comb begin
    x0   = x == XW'(BOARD_X0);
    xw   = ox == OW'(SQ_SIZE - 1);
    ox_n = (x0 || xw) ? '0 : ox + 1'b1;
    cx_n = x0 ? '0 : cx + 3'(xw);
    xa0  = ox_n == OW'(BORDER);
    sx_n = (xa0 || sx == AW'(ART_SCALE - 1)) ? '0 : sx + 1'b1;
    ax_n = xa0 ? '0 : ax + 3'(sx == AW'(ART_SCALE - 1));
    y0   = y == YW'(BOARD_Y0);
    yw   = oy == OW'(SQ_SIZE - 1);
    oy_n = (y0 || yw) ? '0 : oy + 1'b1;
    cy_n = y0 ? '0 : cy + 3'(yw);
    ya0  = oy_n == OW'(BORDER);
    sy_n = (ya0 || sy == AW'(ART_SCALE - 1)) ? '0 : sy + 1'b1;
    ay_n = ya0 ? '0 : ay + 3'(sy == AW'(ART_SCALE - 1));
  end

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      {ox, cx, ax, sx, oy, cy, ay, sy} <= '0;
      s1_inb <= 1'b0;
      s1_act <= 1'b0;
      s1_fs  <= 1'b0;
      s1_hs  <= !SYNC_ACTIVE;
      s1_vs  <= !SYNC_ACTIVE;
    end else begin
      ox <= ox_n;
      cx <= cx_n;
      ax <= ax_n;
      sx <= sx_n;
      if (x == '0) begin
        oy <= oy_n;
        cy <= cy_n;
        ay <= ay_n;
        sy <= sy_n;
      end
      s1_inb <= (x >= XW'(BOARD_X0)) && (x < XW'(BOARD_X0 + 8 * SQ_SIZE)) &&
                (y >= YW'(BOARD_Y0)) && (y < YW'(BOARD_Y0 + 8 * SQ_SIZE));
      s1_act <= act_raw;
      s1_fs  <= (x == '0) && (y == '0);
      s1_hs  <= hs_raw;
      s1_vs  <= vs_raw;
    end

  // S2: flip to board index, look up the square and sprite, precompute priority flags.
  logic [5:0] idx;
  logic [3:0] sq;
  logic s2_vis, s2_border, s2_cur, s2_sel, s2_last, s2_spr, s2_black, s2_out, s2_dark;
  logic s2_hs, s2_vs, s2_fs;

  always_comb begin
    idx = sh_flip ? {~cy, ~cx} : {cy, cx};
    sq  = sh_board[{idx, 2'b00} +: 4];
  end

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      {s2_vis, s2_border, s2_cur, s2_sel, s2_last, s2_spr, s2_black, s2_out, s2_dark} <= '0;
      s2_fs <= 1'b0;
      s2_hs <= !SYNC_ACTIVE;
      s2_vs <= !SYNC_ACTIVE;
    end else begin
      s2_vis    <= s1_act && s1_inb;
      s2_border <= (ox < OW'(BORDER)) || (ox >= OW'(SQ_SIZE - BORDER)) ||
                   (oy < OW'(BORDER)) || (oy >= OW'(SQ_SIZE - BORDER));
      s2_cur    <= blink && (idx == sh_cur);
      s2_sel    <= sh_sel_en && (idx == sh_sel);
      s2_last   <= sh_last_en && ((idx == sh_from) || (idx == sh_to));
      s2_spr    <= sprite_bit(sq[2:0], ay, ax);
      s2_black  <= sq[3] == COL_BLACK;
      s2_out    <= sq[2:0] == P_OUT;
      s2_dark   <= cy[0] ^ cx[0];
      s2_fs     <= s1_fs;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
    end

  // S3: colour priority mux.
  logic [7:0] sq_rgb, bord_rgb, int_rgb, rgb_n;

  always_comb begin
    sq_rgb   = s2_dark ? RGB_DARK : RGB_LIGHT;
    bord_rgb = s2_cur ? RGB_CURSOR : s2_sel ? RGB_SELECTED : s2_last ? RGB_LASTMOVE : sq_rgb;
    int_rgb  = s2_out ? RGB_OUTSIDE :
               s2_spr ? (s2_black ? RGB_BLACK_PC : RGB_WHITE_PC) :
               s2_last ? RGB_LASTMOVE : sq_rgb;
    rgb_n    = !s2_vis ? RGB_OUTSIDE : s2_border ? bord_rgb : int_rgb;
  end

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      {R, G, B}   <= '0;
      FRAME_START <= 1'b0;
      HSYNC       <= !SYNC_ACTIVE;
      VSYNC       <= !SYNC_ACTIVE;
    end else begin
      {R, G, B}   <= rgb_n;
      FRAME_START <= s2_fs;
      HSYNC       <= s2_hs;
      VSYNC       <= s2_vs;
    end
endmodule

// File: tb/tb_board_renderer_pipe.sv
// tb_board_renderer_pipe: directed checks of a reduced-geometry renderer (92x86 frame, 10px squares).
module tb_board_renderer_pipe;
  localparam int HT = 92;
  localparam int FL = 92 * 86;
  localparam logic [7:0] LIGHT = 8'hFA, DARK = 8'hA0, WPC = 8'hDA, BPC = 8'h49;
  localparam logic [7:0] CUR = 8'h03, SEL = 8'hE0, LAST = 8'hD4, OFF = 8'h00;

  logic         CLK = 1'b0, RESET = 1'b1;
  logic [255:0] BOARD = '0;
  logic [5:0]   CURSOR_ADDR = 6'h3F, SELECT_ADDR = '0, LAST_FROM = '0, LAST_TO = '0;
  logic         SELECT_EN = 1'b0, LAST_EN = 1'b0, FLIP = 1'b0;
  logic         HSYNC, VSYNC, FRAME_START;
  logic [2:0]   R, G;
  logic [1:0]   B;
  logic [7:0]   rgb;
  int total = 0, bad = 0, cyc = 0;

  assign rgb = {R, G, B};
  always #5 CLK = ~CLK;

  board_renderer_pipe #(
    .H_ACTIVE(84), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(82), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_ACTIVE(1'b0), .BOARD_X0(2), .BOARD_Y0(1),
    .SQ_SIZE(10), .BORDER(1), .ART_SCALE(1), .BLINK_FRAMES(1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .BOARD(BOARD), .CURSOR_ADDR(CURSOR_ADDR),
    .SELECT_ADDR(SELECT_ADDR), .SELECT_EN(SELECT_EN), .LAST_FROM(LAST_FROM),
    .LAST_TO(LAST_TO), .LAST_EN(LAST_EN), .FLIP(FLIP), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .R(R), .G(G), .B(B), .FRAME_START(FRAME_START)
  );

  task automatic go(input int k);
    while (cyc < k) begin
      @(posedge CLK);
      cyc++;
    end
    #1;
  endtask

  // output for pixel (px,py) of frame f appears 3 clocks after the counter reaches it
  task automatic at(input int f, input int px, input int py);
    go(f * FL + py * HT + px + 3);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #22;
    chk("rst_hsync", 8'(HSYNC), 8'd1);
    chk("rst_vsync", 8'(VSYNC), 8'd1);
    chk("rst_rgb", rgb, OFF);
    chk("rst_fs", 8'(FRAME_START), 8'd0);
    @(negedge CLK);
    RESET = 1'b0;
    cyc = 0;
    go(3);   chk("f0_fs_on", 8'(FRAME_START), 8'd1);
    go(4);   chk("f0_fs_off", 8'(FRAME_START), 8'd0);
    at(0, 85, 0); chk("hs_before", 8'(HSYNC), 8'd1);
    at(0, 86, 0); chk("hs_first", 8'(HSYNC), 8'd0);
    at(0, 89, 0); chk("hs_last", 8'(HSYNC), 8'd0);
    at(0, 90, 0); chk("hs_after", 8'(HSYNC), 8'd1);
    at(0, 3, 2);  chk("f0_light", rgb, LIGHT);
    at(0, 13, 2); chk("f0_dark", rgb, DARK);
    BOARD = '0;
    BOARD[3:0]     = 4'b0001;
    BOARD[115:112] = 4'b1010;
    CURSOR_ADDR = 6'd9;
    SELECT_ADDR = 6'd9;
    SELECT_EN = 1'b1;
    LAST_FROM = 6'd12;
    LAST_TO = 6'd28;
    LAST_EN = 1'b1;
    at(0, 1, 10);  chk("out_left", rgb, OFF);
    at(0, 82, 10); chk("out_right", rgb, OFF);
    at(0, 12, 11); chk("midframe_sq9", rgb, LIGHT);
    at(0, 45, 33); chk("midframe_sq28", rgb, DARK);
    at(0, 10, 81); chk("out_below", rgb, OFF);
    at(0, 0, 82);  chk("vs_before", 8'(VSYNC), 8'd1);
    at(0, 0, 83);  chk("vs_first", 8'(VSYNC), 8'd0);
    at(1, -1, 0);  chk("f1_fs_pre", 8'(FRAME_START), 8'd0);
    at(1, 0, 0);   chk("f1_fs_on", 8'(FRAME_START), 8'd1);
    at(1, 3, 2);   chk("pawn_blank_art", rgb, LIGHT);
    at(1, 7, 5);   chk("pawn_art34", rgb, WPC);
    at(1, 12, 11); chk("cursor_on", rgb, CUR);
    at(1, 42, 11); chk("from_border", rgb, LAST);
    at(1, 15, 14); chk("sq9_interior", rgb, LIGHT);
    at(1, 45, 14); chk("from_interior", rgb, LAST);
    at(1, 42, 31); chk("to_border", rgb, LAST);
    at(1, 43, 32); chk("to_interior", rgb, LAST);
    at(1, 45, 34); chk("knight_pixel", rgb, BPC);
    at(2, 12, 11); chk("cursor_off_sel", rgb, SEL);
    FLIP = 1'b1;
    at(2, 77, 75); chk("flip_not_yet", rgb, LIGHT);
    at(3, 7, 5);   chk("flip_sq0_empty", rgb, LIGHT);
    at(3, 62, 61); chk("flip_cursor", rgb, CUR);
    at(3, 77, 75); chk("flip_pawn", rgb, WPC);
    at(4, 30, 20); chk("pre_reset_px", rgb, DARK);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_rgb", rgb, OFF);
    chk("midrst_hsync", 8'(HSYNC), 8'd1);
    chk("midrst_vsync", 8'(VSYNC), 8'd1);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    cyc = 0;
    go(3);        chk("rst2_fs", 8'(FRAME_START), 8'd1);
    at(0, 86, 0); chk("rst2_hs", 8'(HSYNC), 8'd0);
    at(0, 3, 2);  chk("rst2_light", rgb, LIGHT);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
